// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of the shared code/data memory.
// Each access is latched at grant and held on the memory pins for LATENCY cycles.
module mem_arbiter #(
   parameter int WIDTH   = 8,
   parameter int LATENCY = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hold,
   input  logic             req0,
   input  logic             we0,
   input  logic [WIDTH-1:0] addr0,
   input  logic [WIDTH-1:0] wdata0,
   output logic             gnt0,
   output logic             done0,
   input  logic             req1,
   input  logic             we1,
   input  logic [WIDTH-1:0] addr1,
   input  logic [WIDTH-1:0] wdata1,
   output logic             gnt1,
   output logic             done1,
   output logic [WIDTH-1:0] rdata,
   output logic             memread,
   output logic             memwrite,
   output logic [WIDTH-1:0] mar,
   output logic [WIDTH-1:0] writedata,
   input  logic [WIDTH-1:0] memdata
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t     state;
   logic       op;
   logic       last;
   logic [3:0] cnt;

   assign memread  = (state == BUSY) && !op;
   assign memwrite = (state == BUSY) && op;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         last      <= 1'b1;
         op        <= 1'b0;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         done0     <= 1'b0;
         done1     <= 1'b0;
         rdata     <= '0;
         mar       <= '0;
         writedata <= '0;
      end else begin
         done0 <= 1'b0;
         done1 <= 1'b0;
         case (state)
            IDLE: begin
               if (!hold && (req0 || req1)) begin
                  // On a tie the port that was not served last wins.
                  if (req0 && (!req1 || last)) begin
                     mar       <= addr0;
                     writedata <= wdata0;
                     op        <= we0;
                     gnt0      <= 1'b1;
                     last      <= 1'b0;
                  end else begin
                     mar       <= addr1;
                     writedata <= wdata1;
                     op        <= we1;
                     gnt1      <= 1'b1;
                     last      <= 1'b1;
                  end
                  cnt   <= CNT_INIT;
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  if (!op) begin
                     rdata <= memdata;
                  end
                  done0 <= gnt0;
                  done1 <= gnt1;
                  gnt0  <= 1'b0;
                  gnt1  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single external code/data memory (8-bit address/data, memread/memwrite/mar/writedata/memdata interface) between the mips core (port 0) and a second requester (port 1, loader/debug DMA).
- Serialises accesses with round-robin fairness and holds each access for a fixed memory latency.
- Returns read data and a one-cycle done pulse to the requester that was served.
- Sits between the core and the memory in the top level; the memory side is pin-compatible with the existing memory.

Parameters:
- WIDTH, 8, address and data width.
- LATENCY, 1, cycles memread/memwrite is held per access (legal 1..15).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- hold  input  1  when high, no new grant is issued; an access in flight completes normally.
- req0  input  1  port 0 request; held high until done0.
- we0  input  1  port 0 access type: 1 = write, 0 = read.
- addr0  input  WIDTH  port 0 address.
- wdata0  input  WIDTH  port 0 write data.
- gnt0  output  1  port 0 is being served.
- done0  output  1  one-cycle pulse when port 0 access completes.
- req1, we1, addr1, wdata1, gnt1, done1: same as port 0, for port 1.
- rdata  output  WIDTH  read data of the most recent completed read; shared by both ports.
- memread  output  1  to memory.
- memwrite  output  1  to memory.
- mar  output  WIDTH  memory address.
- writedata  output  WIDTH  memory write data.
- memdata  input  WIDTH  memory read data.

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-access):
  - state=IDLE, cnt=0, last=1 (so port 0 wins the first tie).
  - All outputs are 0: gnt*, done*, rdata, memread, memwrite, mar, writedata.
  - An in-flight access is abandoned, with no done pulse.
- States: IDLE, BUSY.
- IDLE:
  - Requests are sampled at the rising edge.
  - If hold=0 and any req is high, the winner is chosen:
    - only one req high -> that port;
    - both high -> the port != last.
  - At that edge: latch winner addr/wdata/we into mar/writedata/op; set gnt<winner>=1 and last=winner; cnt=LATENCY-1; go to BUSY.
  - If hold=1 or no req: stay in IDLE with all memory strobes 0.
- BUSY:
  - memread = ~op and memwrite = op, both combinationally from state.
  - mar and writedata stay stable for the whole access.
  - At each edge with cnt!=0: cnt decrements.
  - At the edge with cnt==0:
    - reads only: rdata<=memdata;
    - done<winner> is high for the next cycle;
    - gnt cleared; go to IDLE.
- Timing:
  - Strobe active for exactly LATENCY cycles.
  - Request-to-done = LATENCY+1 edges.
  - Peak throughput: one access per LATENCY+1 cycles.
  - The IDLE cycle in which done is high is an arbitration cycle:
    - a req still high there is treated as a new request;
    - a requester with no further work must drop req in the done cycle.
- rdata holds its value until the next completed read; writes do not change it.
- Address/data changes on a granted port during BUSY are ignored, because they were latched at grant.
- Never more than one of gnt0/gnt1, done0/done1, or memread/memwrite high at once.
- hold rising during BUSY does not abort the access; it only blocks the next grant.
- Requests are never dropped: a losing req stays pending and wins at the next arbitration, since last now points at the other port.

Test Plan:
- Reset/idle: reset 22 ns, no req -> all outputs 0; memread=memwrite=0 for 10 cycles.
- Single read, LATENCY=1: req0=1, we0=0, addr0=8'h4C, memory[4C]=8'h07 -> memread high for 1 cycle with mar=4C; done0 pulse on the next cycle; rdata=07; gnt1 never high.
- Single write, LATENCY=3: req1=1, we1=1, addr1=8'h10, wdata1=8'h5A -> memwrite high for 3 consecutive cycles with mar=10 and writedata=5A; done1 after 4 edges; memory[10]=5A; rdata unchanged.
- Contention/fairness: req0 and req1 both held high for 6 accesses -> grants alternate 0,1,0,1,0,1 (first is port 0 after reset); each done is a single cycle; strobes never overlap.
- Hold: hold=1 with req0 pending for 5 cycles -> no strobe; hold drops to 0 -> grant at the next edge. Setting hold=1 mid-BUSY still completes with done0.
- Reset mid-access: LATENCY=4, reset asserted asynchronously in the 2nd BUSY cycle -> memread, gnt0 and mar drop to 0 immediately; no done0. After release with req0 still high -> fresh access completes normally.
